// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT stage sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } fft_state_t;

    localparam int LOG2N_MIN     = 2;
    localparam int LOG2N_MAX     = 10;
    localparam int STAGE_GAP_MAX = 15;

    function automatic int fft_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int fft_stg_w(input int log2n);
        return (fft_clog2(log2n) > 1) ? fft_clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly) -> top/bottom operand address and twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    localparam int STG_W = fft_stg_w(LOG2N)
) (
    input  logic [STG_W-1:0] s,
    input  logic [LOG2N-2:0] b,
    output logic [LOG2N-1:0] top,
    output logic [LOG2N-1:0] bot,
    output logic [LOG2N-2:0] tw
);

    localparam logic [LOG2N-1:0] ONE  = 1;
    localparam logic [LOG2N-2:0] ONES = '1;
    localparam logic [STG_W-1:0] LAST = STG_W'(LOG2N - 1);

    logic [LOG2N-2:0] mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-2:0] grp;
    logic [STG_W-1:0] tw_sh;

    always_comb begin
        mask  = ~(ONES << s);
        pos   = b & mask;
        grp   = b >> s;
        // grp occupies the bits above the half-block, so the shifted group cannot overflow N
        top   = ({grp, 1'b0} << s) | {1'b0, pos};
        bot   = top | (ONE << s);
        tw_sh = LAST - s;
        tw    = pos << tw_sh;
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Walks every butterfly of a 2^LOG2N-point iterative radix-2 DIT FFT, with
// start/busy/done handshake, stall, inter-stage drain gap and IFFT conjugate flag.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N     = 3,
    parameter int STAGE_GAP = 0,
    localparam int STG_W    = fft_stg_w(LOG2N)
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic             stall,
    output logic             busy,
    output logic             sel_valid,
    output logic [LOG2N-1:0] mux_sel1,
    output logic [LOG2N-1:0] mux_sel_bot,
    output logic [LOG2N-2:0] mux_sel2,
    output logic [STG_W-1:0] stage,
    output logic             tw_conj,
    output logic             done
);

    if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX ||
        STAGE_GAP < 0 || STAGE_GAP > STAGE_GAP_MAX) begin : g_bad_param
        $error("fft_stage_sequencer: LOG2N or STAGE_GAP out of range");
    end

    localparam logic [LOG2N-2:0] B_ONE    = 1;
    localparam logic [LOG2N-2:0] B_LAST   = '1;
    localparam logic [STG_W-1:0] S_ONE    = 1;
    localparam logic [STG_W-1:0] S_LAST   = STG_W'(LOG2N - 1);
    localparam logic [3:0]       GAP_LOAD = (STAGE_GAP > 0) ? 4'(STAGE_GAP - 1) : 4'd0;

    fft_state_t       state, state_nx;
    logic [LOG2N-2:0] b_q, b_nx;
    logic [STG_W-1:0] s_q, s_nx;
    logic [3:0]       gap_q, gap_nx;
    logic             inv_q, inv_nx;
    logic             present;

    logic [LOG2N-1:0] top_c, bot_c;
    logic [LOG2N-2:0] tw_c;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .s   (s_q),
        .b   (b_q),
        .top (top_c),
        .bot (bot_c),
        .tw  (tw_c)
    );

    always_comb begin
        state_nx = state;
        b_nx     = b_q;
        s_nx     = s_q;
        gap_nx   = gap_q;
        inv_nx   = inv_q;
        present  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    inv_nx   = inverse;
                    b_nx     = '0;
                    s_nx     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    present = 1'b1;
                    if (b_q != B_LAST) begin
                        b_nx = b_q + B_ONE;
                    end else if (s_q != S_LAST) begin
                        b_nx = '0;
                        s_nx = s_q + S_ONE;
                        if (STAGE_GAP > 0) begin
                            state_nx = GAP;
                            gap_nx   = GAP_LOAD;
                        end
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            GAP: begin
                if (!stall) begin
                    if (gap_q == 4'd0) state_nx = RUN;
                    else               gap_nx   = gap_q - 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            b_q         <= '0;
            s_q         <= '0;
            gap_q       <= '0;
            inv_q       <= 1'b0;
            busy        <= 1'b0;
            sel_valid   <= 1'b0;
            mux_sel1    <= '0;
            mux_sel_bot <= '0;
            mux_sel2    <= '0;
            stage       <= '0;
            done        <= 1'b0;
        end else begin
            state     <= state_nx;
            b_q       <= b_nx;
            s_q       <= s_nx;
            gap_q     <= gap_nx;
            inv_q     <= inv_nx;
            busy      <= (state == RUN) || (state == GAP);
            sel_valid <= present;
            done      <= (state == DONE);
            // while stalled the pending butterfly is shown but not qualified
            if (state == RUN) begin
                mux_sel1    <= top_c;
                mux_sel_bot <= bot_c;
                mux_sel2    <= tw_c;
                stage       <= s_q;
            end
        end
    end

    assign tw_conj = inv_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: LOG2N=3 (gap 0 and 2) and LOG2N=4 sequencers driven from shared inputs.
module tb_fft_stage_sequencer;

    logic clk2 = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic inverse = 1'b0;
    logic stall = 1'b0;

    logic       a_busy, a_valid, a_conj, a_done;
    logic [2:0] a_top, a_bot;
    logic [1:0] a_tw, a_stage;

    logic       g_busy, g_valid, g_conj, g_done;
    logic [2:0] g_top, g_bot;
    logic [1:0] g_tw, g_stage;

    logic       d_busy, d_valid, d_conj, d_done;
    logic [3:0] d_top, d_bot;
    logic [2:0] d_tw;
    logic [1:0] d_stage;

    int n_chk = 0;
    int n_pass = 0;

    int exp_top[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_bot[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    always #5 clk2 = ~clk2;

    fft_stage_sequencer #(.LOG2N(3), .STAGE_GAP(0)) u_a (
        .clk2(clk2), .rst(rst), .start(start), .inverse(inverse), .stall(stall),
        .busy(a_busy), .sel_valid(a_valid), .mux_sel1(a_top), .mux_sel_bot(a_bot),
        .mux_sel2(a_tw), .stage(a_stage), .tw_conj(a_conj), .done(a_done)
    );

    fft_stage_sequencer #(.LOG2N(3), .STAGE_GAP(2)) u_g (
        .clk2(clk2), .rst(rst), .start(start), .inverse(inverse), .stall(stall),
        .busy(g_busy), .sel_valid(g_valid), .mux_sel1(g_top), .mux_sel_bot(g_bot),
        .mux_sel2(g_tw), .stage(g_stage), .tw_conj(g_conj), .done(g_done)
    );

    fft_stage_sequencer #(.LOG2N(4), .STAGE_GAP(0)) u_d (
        .clk2(clk2), .rst(rst), .start(start), .inverse(inverse), .stall(stall),
        .busy(d_busy), .sel_valid(d_valid), .mux_sel1(d_top), .mux_sel_bot(d_bot),
        .mux_sel2(d_tw), .stage(d_stage), .tw_conj(d_conj), .done(d_done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    // start is sampled at the edge inside this task: that edge is cycle 0
    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k, n4, k4, n_done;
        bit v, vg;

        // reset state
        idle(2);
        rst = 1'b0;
        tick();
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_top", a_top, 0);
        chk("rst_stage", a_stage, 0);
        chk("rst_conj", a_conj, 0);

        // plain run on all three instances
        run_start();
        n4 = 0;
        k4 = 0;
        for (int c = 1; c <= 34; c++) begin
            tick();
            v = (c >= 1 && c <= 12);
            chk("s1_valid", a_valid, v);
            chk("s1_busy", a_busy, v);
            chk("s1_done", a_done, c == 13);
            if (v) begin
                chk("s1_top", a_top, exp_top[c-1]);
                chk("s1_bot", a_bot, exp_bot[c-1]);
                chk("s1_tw", a_tw, exp_tw[c-1]);
                chk("s1_stage", a_stage, (c - 1) / 4);
            end
            vg = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
            chk("gap_valid", g_valid, vg);
            chk("gap_busy", g_busy, c >= 1 && c <= 16);
            chk("gap_done", g_done, c == 17);
            if (d_valid) begin
                n4++;
                if (d_stage == 2'd3) begin
                    chk("n16_s3_top", d_top, k4);
                    chk("n16_s3_bot", d_bot, k4 + 8);
                    chk("n16_s3_tw", d_tw, k4);
                    k4++;
                end
            end
            chk("n16_done", d_done, c == 33);
        end
        chk("n16_valid_count", n4, 32);
        chk("n16_s3_count", k4, 8);
        idle(4);

        // stall during stage 0, sampled at edges 3..5
        run_start();
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            v = (c >= 1 && c <= 2) || (c >= 6 && c <= 15);
            chk("stall_valid", a_valid, v);
            chk("stall_done", a_done, c == 16);
            if (c >= 3 && c <= 5) begin
                chk("stall_hold_top", a_top, 4);
                chk("stall_hold_stage", a_stage, 0);
                chk("stall_busy", a_busy, 1);
            end
            if (a_valid && k < 12) begin
                chk("stall_seq_top", a_top, exp_top[k]);
                chk("stall_seq_bot", a_bot, exp_bot[k]);
                chk("stall_seq_tw", a_tw, exp_tw[k]);
            end
            if (a_valid) k++;
            if (c == 2) stall = 1'b1;
            if (c == 5) stall = 1'b0;
        end
        chk("stall_count", k, 12);
        idle(20);

        // inverse latched at start; later changes and a second start ignored
        inverse = 1'b1;
        run_start();
        n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c <= 12) chk("inv_conj", a_conj, 1);
            chk("inv_done", a_done, c == 13);
            if (a_done) n_done++;
            if (c == 4) inverse = 1'b0;
            if (c == 6) start = 1'b1;
            if (c == 7) start = 1'b0;
        end
        chk("inv_done_count", n_done, 1);
        chk("inv_idle_busy", a_busy, 0);
        idle(20);

        // asynchronous reset mid-transform, then a fresh run
        run_start();
        idle(6);
        rst = 1'b1;
        #2;
        chk("arst_valid", a_valid, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_top", a_top, 0);
        chk("arst_stage", a_stage, 0);
        chk("arst_conj", a_conj, 0);
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_done || a_busy) n_done++;
        end
        chk("arst_no_done", n_done, 0);
        run_start();
        k = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin
                chk("rerun_first_top", a_top, 0);
                chk("rerun_first_stage", a_stage, 0);
            end
            chk("rerun_done", a_done, c == 13);
            if (a_valid && k < 12) chk("rerun_top", a_top, exp_top[k]);
            if (a_valid) k++;
        end
        chk("rerun_count", k, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Parametrised successor to the fixed 5-state FFT mux controller: sequences every butterfly of an iterative radix-2 DIT FFT of 2^LOG2N points.
- Per butterfly, emits the top and bottom operand addresses, the twiddle index, and stage/valid qualifiers.
- Adds a start/busy/done handshake, a stall input, a configurable inter-stage drain gap, and an inverse-FFT conjugate flag.
- Sits between the top-level FFT controller and the datapath muxes, butterfly unit and twiddle ROM. Input data is stored in bit-reversed order.

Parameters:
- LOG2N, 3, log2 of FFT size; legal 2..10.
- STAGE_GAP, 0, idle cycles inserted between stages for datapath pipeline drain; legal 0..15.
- STG_W, derived = max(1, clog2(LOG2N)), stage index width; not overridable.

Ports:
- clk2  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- inverse  in  1  sampled with an accepted start; selects IFFT.
- stall  in  1  freezes sequencing while high in RUN/GAP.
- busy  out  1  high from the cycle after start is accepted until done.
- sel_valid  out  1  the address outputs describe a live butterfly this cycle.
- mux_sel1  out  LOG2N  top operand address.
- mux_sel_bot  out  LOG2N  bottom operand address.
- mux_sel2  out  LOG2N-1  twiddle ROM index.
- stage  out  STG_W  current stage, 0..LOG2N-1.
- tw_conj  out  1  conjugate twiddle; equals the latched inverse.
- done  out  1  one-cycle pulse after the final butterfly.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-transform aborts immediately with no done pulse.
- All outputs are registered.
- States and transitions:
  - IDLE: start=1 → RUN; latch inverse; zero b and s.
  - RUN: if stall=0, present butterfly (s, b).
    - b < N/2-1: increment b.
    - b = N/2-1 and s < LOG2N-1: b←0, s←s+1; go to GAP if STAGE_GAP>0, else stay in RUN.
    - b = N/2-1 and s = LOG2N-1: → DONE.
  - GAP: sel_valid=0; counts STAGE_GAP cycles (stall freezes the count), then → RUN.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Address mapping for butterfly b of stage s, with half=2^s:
  - pos = b & (half-1); grp = b >> s.
  - mux_sel1 = grp·2·half + pos.
  - mux_sel_bot = mux_sel1 + half.
  - mux_sel2 = pos << (LOG2N-1-s).
- Latency: start sampled at edge k → first valid butterfly presented after edge k+1.
- Total valid cycles = LOG2N·2^(LOG2N-1). Busy length = that + (LOG2N-1)·STAGE_GAP + stall cycles.
- Stall:
  - sel_valid=0 and address/stage outputs hold their last values; counters do not advance.
  - Stall in IDLE/DONE has no effect.
  - Stall released: the butterfly that was pending is presented next cycle; none is skipped or repeated.
- Boundary cases:
  - start while busy: ignored.
  - start in the DONE cycle: ignored.
  - start and stall together in IDLE: start accepted.
  - inverse changing mid-transform: ignored; tw_conj is constant for the whole transform.
- Wrap-around: b and s never wrap inside a transform; both return to 0 only through IDLE.
- Outside valid cycles the address outputs hold; sinks must qualify them with sel_valid.

Decomposition:
- Package fft_pkg:
  - state enum (IDLE, RUN, GAP, DONE);
  - clog2 helper;
  - STG_W derivation;
  - legal-range constants for LOG2N and STAGE_GAP.
- Sub-module fft_addr_gen: purely combinational (s, b) → {top, bot, tw} mapping, parametrised by LOG2N. Reusable by the twiddle-ROM checker.

Test Plan:
- LOG2N=3, STAGE_GAP=0; start pulse at cycle 0 → sel_valid high cycles 1..12, done at 13, busy high 1..12. Sequence:
  - stage 0: top 0,2,4,6; bot 1,3,5,7; tw 0,0,0,0.
  - stage 1: top 0,1,4,5; bot 2,3,6,7; tw 0,2,0,2.
  - stage 2: top 0..3; bot 4..7; tw 0,1,2,3.
- LOG2N=3, STAGE_GAP=2 → sel_valid low 2 cycles after cycles 4 and 10; done at cycle 17.
- Stall held cycles 3..5 during stage 0 → outputs hold top=4 (butterfly 2) with sel_valid=0; top=4 is presented once, at cycle 6; done shifts to cycle 16.
- inverse=1 with start, inverse=0 at cycle 5, second start at cycle 7 → tw_conj=1 throughout; second start ignored; single done.
- rst asserted at cycle 6 → all outputs 0 asynchronously, no done. New start after release → full 12-butterfly run from stage 0.
- LOG2N=4 → 32 valid cycles. Stage 3 tw = 0..7 and bot = top+8. Done at cycle 33.
